cpu_panel_ctrl: RTL and testbench
=================================

Name: cpu_panel_ctrl

Overview:
- Parametrised front-panel controller between board switches/keys and the CPU core.
- Replaces raw key-as-clock and switch-gated wiring with synchronised, debounced inputs.
- Generates a single-cycle CPU clock-enable (free-run divider or single-step) and a programming-mode RAM write port with captured address/data.
- The CPU core runs on CLK qualified by cpu_clk_en; no derived clocks.

Parameters:
ADDR_W, 4, width of the programming address
DATA_W, 8, width of the programming data word
DIV_W, 16, width of the free-run divider compare value
DEBOUNCE_CYCLES, 250000, cycles a key level must be stable before it is accepted (minimum 2)
CNT_W, 16, width of the executed-cycle counter

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
div_sel  in  DIV_W  free-run period minus 1, in CLK cycles
step_mode  in  1  1 = single-step from step_key_n; 0 = free-run divider
prog_mode  in  1  1 = programming mode; CPU is stalled
step_key_n  in  1  raw active-low step key, asynchronous
write_key_n  in  1  raw active-low write key, asynchronous
sw_addr  in  ADDR_W  switch address
sw_data  in  DATA_W  switch data
halt  in  1  CPU halt flag
cpu_clk_en  out  1  one-CLK enable pulse per CPU cycle
prog_wen  out  1  one-CLK RAM write strobe
prog_addr  out  ADDR_W  programming address, registered
prog_data  out  DATA_W  programming data, registered
cyc_count  out  CNT_W  saturating count of cpu_clk_en pulses since reset

Behaviour:
- Reset values: all outputs 0; all state machines in IDLE; divider counter 0.
- Key inputs:
  - Each key passes through a 2-FF synchroniser, then a debounce FSM.
  - Debounce FSM states:
    - IDLE: released; synced low → WAIT_PRESS, clear counter.
    - WAIT_PRESS: synced high → IDLE. Counter reaches DEBOUNCE_CYCLES-1 → PRESSED, emit one-cycle press event.
    - PRESSED: synced high → WAIT_RELEASE, clear counter.
    - WAIT_RELEASE: synced low → PRESSED. Counter reaches DEBOUNCE_CYCLES-1 → IDLE.
  - Exactly one event per accepted press. Holding a key never repeats.
  - Latency from raw key low to event: 2 + DEBOUNCE_CYCLES CLK cycles.
- Clock enable:
  - Blocked when prog_mode=1 or halt=1: cpu_clk_en forced 0, divider counter held at 0, step events discarded.
  - Free-run (step_mode=0): counter increments each cycle. When counter == div_sel, pulse cpu_clk_en and reset counter to 0. Period is div_sel+1 cycles; div_sel=0 gives a pulse every cycle.
  - div_sel change mid-count: new value is compared from the next cycle. If counter > new div_sel, the counter wraps naturally at 2^DIV_W (no early pulse).
  - Step (step_mode=1): one cpu_clk_en pulse, 1 cycle after each step event. Divider counter held at 0.
  - step_mode toggle clears the divider counter.
- cyc_count: increments on every cpu_clk_en pulse and saturates at all-ones.
- Programming:
  - In prog_mode, a write event loads prog_addr/prog_data and asserts prog_wen on the next cycle for exactly 1 cycle.
  - prog_addr/prog_data hold their value until the next write.
  - Write events outside prog_mode are discarded.
  - prog_mode falling during the prog_wen cycle does not truncate the strobe.
- Reset mid-operation: asynchronous clear of everything, including a pending strobe; no pulse after reset release until a new event.

Optional Feature:
- Macro PANEL_AUTOINC_EN.
- Defined:
  - On prog_mode rising edge, prog_addr loads sw_addr.
  - Each write stores sw_data at the current prog_addr, then prog_addr increments after the strobe, modulo 2^ADDR_W (all-ones wraps to 0).
  - sw_addr is ignored until the next prog_mode entry.
- Undefined: prog_addr = sw_addr captured at each write event; no increment logic is synthesised.

Test Plan:
- Free-run, DEBOUNCE_CYCLES=4, div_sel=3, step_mode=0, prog_mode=0, halt=0 → cpu_clk_en pulses every 4 cycles; cyc_count=5 after 20 cycles.
- Step mode: step_key_n low 2 cycles then high (bounce), then low 10 cycles → exactly one cpu_clk_en pulse at cycle 2+4+1 after the second fall; cyc_count=1.
- halt=1 during free-run with div_sel=0 → cpu_clk_en stays 0, cyc_count frozen. Release halt → pulses resume next cycle.
- prog_mode=1, sw_addr=0x5, sw_data=0xA7, write press → one prog_wen pulse, prog_addr=0x5, prog_data=0xA7, cpu_clk_en=0 throughout.
- PANEL_AUTOINC_EN, enter prog_mode with sw_addr=0xE, three writes of 0x11/0x22/0x33 → strobes at addresses 0xE, 0xF, 0x0; final prog_addr=0x1.
- Assert nRST low while a write event is pending → prog_wen never pulses; all outputs 0; no pulse after release without a new press.

Source files
------------

// File: rtl/cpu_panel_ctrl.sv
// Front-panel controller: synchronised/debounced keys, CPU clock-enable, programming write port.
// Optional PANEL_AUTOINC_EN: prog_addr is loaded on prog_mode entry and auto-increments per write.

module cpu_panel_dbnc #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic press_ev
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Last count is compared one early so that entry into WAIT_PRESS counts as a stable cycle.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} dbnc_st_e;

    dbnc_st_e        st_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic            ev_q;
    logic            synced;

    assign synced   = sync_q[1];
    assign press_ev = ev_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= 2'b11;
            st_q   <= IDLE;
            cnt_q  <= '0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            ev_q   <= 1'b0;
            case (st_q)
                IDLE: begin
                    if (!synced) begin
                        st_q  <= WAIT_PRESS;
                        cnt_q <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (synced) begin
                        st_q <= IDLE;
                    end else if (cnt_q == LAST) begin
                        st_q <= PRESSED;
                        ev_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (synced) begin
                        st_q  <= WAIT_RELEASE;
                        cnt_q <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (!synced) begin
                        st_q <= PRESSED;
                    end else if (cnt_q == LAST) begin
                        st_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

module cpu_panel_ctrl #(
    parameter int ADDR_W          = 4,
    parameter int DATA_W          = 8,
    parameter int DIV_W           = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DIV_W-1:0]  div_sel,
    input  logic              step_mode,
    input  logic              prog_mode,
    input  logic              step_key_n,
    input  logic              write_key_n,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              halt,
    output logic              cpu_clk_en,
    output logic              prog_wen,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic [CNT_W-1:0]  cyc_count
);
    localparam int NUM_KEYS = 2;

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_ev;
    logic                step_ev;
    logic                write_ev;

    assign key_n    = {write_key_n, step_key_n};
    assign step_ev  = key_ev[0];
    assign write_ev = key_ev[1];

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            cpu_panel_dbnc #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
                .CLK      (CLK),
                .nRST     (nRST),
                .key_n    (key_n[g]),
                .press_ev (key_ev[g])
            );
        end
    endgenerate

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              en_q, en_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              step_mode_q;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              blocked;

    assign blocked = prog_mode | halt;

    always_comb begin
        div_cnt_d = div_cnt_q;
        en_d      = 1'b0;
        if (blocked || step_mode || (step_mode != step_mode_q)) begin
            div_cnt_d = '0;
            en_d      = !blocked && step_mode && step_ev;
        end else if (div_cnt_q == div_sel) begin
            div_cnt_d = '0;
            en_d      = 1'b1;
        end else begin
            // A div_sel lowered below the count lets it wrap rather than pulse early.
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        cyc_d = cyc_q;
        if (en_d && (cyc_q != {CNT_W{1'b1}}))
            cyc_d = cyc_q + CNT_W'(1);
    end

`ifdef PANEL_AUTOINC_EN
    logic prog_mode_q;

    always_comb begin
        wen_d  = prog_mode && write_ev;
        addr_d = addr_q;
        data_d = data_q;
        if (wen_q)
            addr_d = addr_q + ADDR_W'(1);
        if (prog_mode && !prog_mode_q)
            addr_d = sw_addr;
        if (wen_d)
            data_d = sw_data;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) prog_mode_q <= 1'b0;
        else       prog_mode_q <= prog_mode;
    end
`else
    always_comb begin
        wen_d  = prog_mode && write_ev;
        addr_d = addr_q;
        data_d = data_q;
        if (wen_d) begin
            addr_d = sw_addr;
            data_d = sw_data;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt_q   <= '0;
            en_q        <= 1'b0;
            cyc_q       <= '0;
            step_mode_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            en_q        <= en_d;
            cyc_q       <= cyc_d;
            step_mode_q <= step_mode;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign cpu_clk_en = en_q;
    assign cyc_count  = cyc_q;
    assign prog_wen   = wen_q;
    assign prog_addr  = addr_q;
    assign prog_data  = data_q;
endmodule

// File: tb/tb_cpu_panel_ctrl.sv
// Self-checking bench for cpu_panel_ctrl (DEBOUNCE_CYCLES=4): vector table plus scoreboarded key sequences.

module tb_cpu_panel_ctrl;
    localparam bit AI =
`ifdef PANEL_AUTOINC_EN
        1'b1;
`else
        1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic [15:0] div_sel;
    logic        step_mode, prog_mode, step_key_n, write_key_n, halt;
    logic [3:0]  sw_addr;
    logic [7:0]  sw_data;
    logic        cpu_clk_en, prog_wen;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [15:0] cyc_count;

    cpu_panel_ctrl #(
        .ADDR_W(4), .DATA_W(8), .DIV_W(16), .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .CLK(CLK), .nRST(nRST), .div_sel(div_sel), .step_mode(step_mode),
        .prog_mode(prog_mode), .step_key_n(step_key_n), .write_key_n(write_key_n),
        .sw_addr(sw_addr), .sw_data(sw_data), .halt(halt),
        .cpu_clk_en(cpu_clk_en), .prog_wen(prog_wen), .prog_addr(prog_addr),
        .prog_data(prog_data), .cyc_count(cyc_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] div;
        logic        hlt;
        logic        stp;
        logic        prg;
        int          n;
        int          pulses;
    } vec_t;

    typedef struct {
        int a;
        int d;
        int cyc;
    } wr_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc_n = 0;
    int  en_cnt = 0;
    int  wen_cnt = 0;
    bit  step_chk = 1'b0;
    int  step_q[$];
    wr_t wr_q[$];
    vec_t vt[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc_n++;
            if (cpu_clk_en) begin
                en_cnt++;
                if (step_chk) begin
                    if (step_q.size() == 0) check("step_extra", 1, 0);
                    else                    check("step_cycle", cyc_n, step_q.pop_front());
                end
            end
            if (prog_wen) begin
                wen_cnt++;
                if (wr_q.size() == 0) begin
                    check("wen_extra", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wen_cycle", cyc_n, e.cyc);
                    check("wen_addr", int'(prog_addr), e.a);
                    check("wen_data", int'(prog_data), e.d);
                end
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        en_cnt = 0;
        wen_cnt = 0;
        cyc_n = 0;
    endtask

    // Press the write key long enough to be accepted, then release and let it settle.
    task automatic do_write(input int a, input int d, input bit expect_strobe);
        wr_t e;
        write_key_n = 1'b0;
        cyc_n = 0;
        if (expect_strobe) begin
            e.a = a; e.d = d; e.cyc = 7;
            wr_q.push_back(e);
        end
        run(9);
        write_key_n = 1'b1;
        run(8);
        check("wen_missing", wr_q.size(), 0);
    endtask

    initial begin
        nRST = 1'b0; div_sel = 16'd3; step_mode = 1'b0; prog_mode = 1'b0;
        step_key_n = 1'b1; write_key_n = 1'b1; halt = 1'b0;
        sw_addr = 4'h0; sw_data = 8'h00;
        #12;
        check("rst_en", int'(cpu_clk_en), 0);
        check("rst_wen", int'(prog_wen), 0);
        check("rst_addr", int'(prog_addr), 0);
        check("rst_data", int'(prog_data), 0);
        check("rst_cyc", int'(cyc_count), 0);

        vt[0] = '{16'd3, 1'b0, 1'b0, 1'b0, 20, 5};
        vt[1] = '{16'd0, 1'b0, 1'b0, 1'b0, 10, 10};
        vt[2] = '{16'd0, 1'b1, 1'b0, 1'b0, 10, 0};
        vt[3] = '{16'd2, 1'b0, 1'b0, 1'b0, 10, 3};
        vt[4] = '{16'd4, 1'b0, 1'b0, 1'b1, 12, 0};
        vt[5] = '{16'd1, 1'b0, 1'b1, 1'b0, 8, 0};
        vt[6] = '{16'd6, 1'b0, 1'b0, 1'b0, 21, 3};
        for (int v = 0; v < 7; v++) begin
            div_sel = vt[v].div; halt = vt[v].hlt;
            step_mode = vt[v].stp; prog_mode = vt[v].prg;
            do_reset();
            run(vt[v].n);
            check($sformatf("vec%0d_pulses", v), en_cnt, vt[v].pulses);
            check($sformatf("vec%0d_cyc", v), int'(cyc_count), vt[v].pulses);
        end

        // halt freezes pulses and count; release resumes on the next cycle
        div_sel = 16'd0; halt = 1'b0; step_mode = 1'b0; prog_mode = 1'b0;
        do_reset();
        run(5);
        halt = 1'b1;
        run(5);
        check("halt_pulses", en_cnt, 5);
        check("halt_cyc", int'(cyc_count), 5);
        halt = 1'b0;
        run(1);
        check("unhalt_en", int'(cpu_clk_en), 1);
        check("unhalt_cyc", int'(cyc_count), 6);

        // lowering div_sel below the running count wraps instead of pulsing early
        div_sel = 16'd9;
        do_reset();
        run(5);
        div_sel = 16'd2;
        run(30);
        check("divsel_wrap", en_cnt, 0);

        // step mode with a bounced press, then a real held press
        div_sel = 16'd0; step_mode = 1'b1; step_chk = 1'b1;
        do_reset();
        run(3);
        step_key_n = 1'b0; run(2);
        step_key_n = 1'b1; run(3);
        step_key_n = 1'b0;
        cyc_n = 0;
        step_q.push_back(7);
        run(12);
        step_key_n = 1'b1;
        run(8);
        check("step_missing", step_q.size(), 0);
        check("step_pulses", en_cnt, 1);
        check("step_cyc", int'(cyc_count), 1);
        halt = 1'b1;
        step_key_n = 1'b0; run(10);
        step_key_n = 1'b1; run(8);
        check("step_halted", en_cnt, 1);
        halt = 1'b0; step_chk = 1'b0; step_mode = 1'b0;

        // programming writes, then a write outside prog_mode
        prog_mode = 1'b1; sw_addr = 4'h5; sw_data = 8'hA7; div_sel = 16'd0;
        do_reset();
        do_write(5, 8'hA7, 1'b1);
        check("prog_addr_hold1", int'(prog_addr), AI ? 6 : 5);
        sw_addr = 4'h3; sw_data = 8'h3C;
        do_write(AI ? 6 : 3, 8'h3C, 1'b1);
        check("prog_addr_hold2", int'(prog_addr), AI ? 7 : 3);
        check("prog_no_en", en_cnt, 0);
        halt = 1'b1; prog_mode = 1'b0;
        sw_addr = 4'h9; sw_data = 8'h55;
        do_write(0, 0, 1'b0);
        check("noprog_wen", wen_cnt, 2);
        check("noprog_addr", int'(prog_addr), AI ? 7 : 3);
        check("noprog_data", int'(prog_data), 8'h3C);

`ifdef PANEL_AUTOINC_EN
        // address loaded on prog_mode entry, increments and wraps per write
        prog_mode = 1'b0; sw_addr = 4'hE;
        do_reset();
        run(2);
        prog_mode = 1'b1;
        run(2);
        sw_addr = 4'h3;
        sw_data = 8'h11; do_write(4'hE, 8'h11, 1'b1);
        sw_data = 8'h22; do_write(4'hF, 8'h22, 1'b1);
        sw_data = 8'h33; do_write(4'h0, 8'h33, 1'b1);
        check("ai_final_addr", int'(prog_addr), 1);
        check("ai_wen", wen_cnt, 3);
`endif

        // reset while a write strobe is pending
        halt = 1'b0; prog_mode = 1'b1; sw_addr = 4'hC; sw_data = 8'h5A;
        do_reset();
        write_key_n = 1'b0;
        run(6);
        nRST = 1'b0;
        write_key_n = 1'b1;
        #2;
        check("mid_rst_wen", int'(prog_wen), 0);
        check("mid_rst_addr", int'(prog_addr), 0);
        check("mid_rst_data", int'(prog_data), 0);
        check("mid_rst_en", int'(cpu_clk_en), 0);
        check("mid_rst_cyc", int'(cyc_count), 0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        wen_cnt = 0;
        run(20);
        check("post_rst_wen", wen_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
